truth_table_sequencer: RTL
==========================

// Module: truth_table_sequencer
// PURPOSE
//  Controller that sequences a combinational gate-function unit (e.g. s = ~a & b).
//  Steps dut_in through all 2^N_IN input combinations and waits SETTLE cycles per vector.
//  Captures dut_out into a truth-table register and compares it against an expected table.
//  Replaces hand-written #1 stimulus benches; sits between a test/config master and the gate unit.
// PARAMETERS
//  N_IN    2  number of function-unit inputs (legal 1..4); table width W = 2**N_IN
//  SETTLE  1  cycles dut_in is held before sampling dut_out (legal 1..15)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  start      in   1      request a sweep; accepted only in IDLE
//  expected   in   W      expected truth table, bit i = f(dut_in==i); latched on accepted start
//  dut_out    in   1      output of the function unit under control
//  dut_in     out  N_IN   input vector driven to the function unit
//  busy       out  1      high from the cycle after accept until DONE inclusive
//  done       out  1      one-cycle pulse, sweep complete
//  pass       out  1      table_out == expected_latched; valid from done, held until next accept
//  table_out  out  W      captured truth table; bit i = sampled dut_out for vector i
//  fail_idx   out  N_IN   lowest index where table_out != expected; 0 when pass=1
// BEHAVIOUR
//  Reset (sync, dominant over all inputs): state=IDLE; dut_in=0, busy=0, done=0, pass=0,
//   table_out=0, fail_idx=0, idx=0, settle counter=0, expected latch=0.
//  FSM states IDLE, SETTLE, SAMPLE, DONE:
//   IDLE:   start=1 -> latch expected, idx=0, dut_in=0, table_out=0, pass=0, cnt=SETTLE-1 -> SETTLE.
//   SETTLE: cnt==0 -> SAMPLE, else cnt--. dut_in stays stable.
//   SAMPLE: at the edge ending this cycle: table_out[idx]<=dut_out.
//           idx==W-1 -> DONE; else idx++, dut_in<=idx+1, cnt=SETTLE-1 -> SETTLE.
//   DONE:   done=1 for this cycle only; pass and fail_idx are registered on entry
//           so they are valid in this cycle; -> IDLE. dut_in returns to 0 in IDLE.
//  Latency: if start is accepted at edge t, dut_in=0 in cycle t+1 and done is high in cycle
//   t+1+W*(SETTLE+1). N_IN=2, SETTLE=1: done in cycle t+9.
//  Each vector is held exactly SETTLE+1 cycles. dut_out is sampled only in SAMPLE.
//  start while busy (SETTLE/SAMPLE/DONE) is ignored; it is neither queued nor restarts the sweep.
//  expected changes after accept have no effect on the current sweep.
//  start in the cycle after DONE (IDLE) is accepted normally (back-to-back sweeps).
//  idx is N_IN+1 bits wide internally; there is no wrap at W-1, termination is explicit.
//  Reset mid-sweep: immediate return to IDLE with reset values; the partial table is discarded.
//  fail_idx is a priority encode, lowest mismatching bit first.
// TESTING
//  1 N_IN=2,SETTLE=1, dut=~a&b (a=dut_in[1],b=dut_in[0]), expected=4'b0010, start pulse
//    -> dut_in 0,1,2,3 each held 2 cycles; done at t+9; table_out=4'b0010, pass=1, fail_idx=0.
//  2 Same dut, expected=4'b1010 -> table_out=4'b0010, pass=0, fail_idx=3.
//  3 Start held high through the whole sweep -> exactly one sweep runs before DONE.
//    A second sweep begins on the IDLE cycle after done; its done is 9 cycles after that accept.
//  4 Reset asserted while dut_in=2 in SETTLE -> next cycle: IDLE, busy=0, table_out=0,
//    dut_in=0; no done pulse.
//  5 SETTLE=3, dut=AND, expected=4'b1000 -> each vector held 4 cycles; done at t+17; pass=1.
//  6 N_IN=1, dut=NOT(dut_in[0]), expected=2'b01 -> done at t+5; table_out=2'b01, pass=1.

Source files
------------

// File: rtl/truth_table_sequencer_if.sv
// Handshake and result bus between a test/config master and the truth table sequencer.
// The sequencer sits on the slave side; the master requests sweeps and reads results.
interface truth_table_sequencer_if #(
    parameter int N_IN = 2
);
    localparam int W = 2 ** N_IN;

    logic            start;
    logic [W-1:0]    expected;
    logic            busy;
    logic            done;
    logic            pass;
    logic [W-1:0]    table_out;
    logic [N_IN-1:0] fail_idx;

    modport master (
        output start, expected,
        input  busy, done, pass, table_out, fail_idx
    );

    modport slave (
        input  start, expected,
        output busy, done, pass, table_out, fail_idx
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps a combinational gate unit through every input combination, captures its truth table
// and compares it against an expected table latched when the sweep is accepted.
module truth_table_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    truth_table_sequencer_if.slave bus,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        dut_in
);
    localparam int W = 2 ** N_IN;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN:0]   IDX_LAST    = (N_IN + 1)'(W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t          state;
    logic [N_IN:0]   idx;
    logic [3:0]      cnt;
    logic [W-1:0]    expected_q;
    logic [W-1:0]    table_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [N_IN-1:0] fail_q;

    logic [W-1:0]    table_next;
    logic [W-1:0]    diff;
    logic [N_IN-1:0] fail_next;

    // Table as it will look once the current sample lands, so the verdict is ready on DONE entry.
    always_comb begin
        table_next = table_q;
        table_next[idx[N_IN-1:0]] = dut_out;
        diff = table_next ^ expected_q;
        fail_next = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (diff[i]) fail_next = N_IN'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            expected_q <= '0;
            table_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= '0;
            dut_in     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        expected_q <= bus.expected;
                        idx        <= '0;
                        dut_in     <= '0;
                        table_q    <= '0;
                        pass_q     <= 1'b0;
                        cnt        <= SETTLE_LAST;
                        busy_q     <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 4'd0) state <= S_SAMPLE;
                    else             cnt   <= cnt - 4'd1;
                end
                S_SAMPLE: begin
                    table_q <= table_next;
                    if (idx == IDX_LAST) begin
                        done_q <= 1'b1;
                        pass_q <= (diff == '0);
                        fail_q <= fail_next;
                        state  <= S_DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                        dut_in <= N_IN'(idx + 1'b1);
                        cnt    <= SETTLE_LAST;
                        state  <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    dut_in <= '0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.table_out = table_q;
    assign bus.fail_idx  = fail_q;
endmodule
